stream_mux2_rr: RTL and testbench
=================================

# stream_mux2_rr

Two-input, one-output stream multiplexer: the merging counterpart of the team's 1-to-2 demultiplexer. It arbitrates between two valid/ready input streams, forwards one packet at a time to a single registered output, and tags each output beat with its source index. A downstream demultiplexer can use that tag to route beats back. Typical placement is in front of a shared link or a shared processing stage.

## Interface
Parameters:
- WIDTH, 8, data width of every stream.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous, active-high.
- in0_data  input  WIDTH  source 0 payload.
- in0_valid  input  1  source 0 beat available.
- in0_last  input  1  source 0 final beat of packet.
- in0_ready  output  1  source 0 beat accepted this cycle when high with in0_valid.
- in1_data / in1_valid / in1_last / in1_ready  same as source 0, for source 1.
- out_data  output  WIDTH  registered payload.
- out_valid  output  1  registered beat available.
- out_last  output  1  registered last-beat flag.
- out_sel  output  1  source index of the current output beat.
- out_ready  input  1  downstream accepts the beat when high with out_valid.

## Operation
- A transfer occurs on any interface in a cycle where valid and ready are both high at the rising edge.
- Output slot: a single register stage.
  - slot_free = !out_valid | out_ready.
  - A beat enters the slot only when slot_free is high.
- Arbiter FSM states:
  - IDLE: no packet in progress.
    - Grant source g. If only one source is valid, g is that source. If both are valid, g = prio. If none is valid, no grant.
    - in_g_ready = slot_free. The other source's ready is 0.
    - Accepted beat with last=1: stay IDLE, prio <= !g.
    - Accepted beat with last=0: go to LOCK_g.
  - LOCK0 / LOCK1: packet from source x is in progress.
    - in_x_ready = slot_free. The other source's ready is 0 regardless of its valid.
    - Accepted beat with last=1: go to IDLE, prio <= !x.
- prio is a 1-bit round-robin pointer. Its reset value is 0, so source 0 is favoured first.
- On acceptance, {out_data, out_last, out_sel} <= {in_g_data, in_g_last, g} and out_valid <= 1.
- If the slot is consumed and no new beat is accepted, out_valid <= 0. out_data, out_last and out_sel hold their last values.
- Packets are never interleaved on the output.
- A source that drops valid mid-packet stalls the output. Lock is held until that source's last beat.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, out_sel=0, in0_ready=0, in1_ready=0, state=IDLE, prio=0.
- Latency: 1 cycle. A beat accepted at edge N is visible on out_* after edge N.
- Throughput: 1 beat per cycle while out_ready stays high.
- in_x_ready depends combinationally on out_ready, the FSM state, prio and the in_valid inputs. There is no combinational path from any data input to any ready output.
- While out_valid=1 and out_ready=0, out_* stay stable and both in_ready signals are 0.
- Simultaneous valid in IDLE: exactly one source is granted, per prio. There is never a dual grant.
- Reset asserted mid-packet: at the next edge all state and outputs take their reset values. The in-flight slot beat is dropped.
- A beat with last=1 is a complete single-beat packet.

## Structure
- Shared package stream_pkg:
  - arb_state_t enum {IDLE, LOCK0, LOCK1}.
  - Default-width constant STREAM_WIDTH=8.
- Sub-module stream_out_reg (WIDTH+2 bit register slot with valid/ready, generating slot_free) holds the output stage.
- The top level holds the FSM, prio and the grant mux.

## Test plan
- Single beat: in0_data=8'hA5, in0_last=1, valid 1 cycle, out_ready=1 -> next cycle out_valid=1, out_data=A5, out_sel=0, out_last=1.
- Contention: both sources send continuous single-beat packets (in0 0x10,0x11; in1 0x20,0x21), out_ready=1 -> output order 10,20,11,21; out_sel 0,1,0,1.
- Packet lock: in0 sends a 3-beat packet 0x01,0x02,0x03 (last on 0x03) while in1 holds valid with 0x55 -> output 01,02,03 then 55. in1_ready stays 0 until after 0x03 is accepted.
- Backpressure: out holds 0x33, out_ready=0 for 5 cycles -> out_* unchanged and both in_ready low for 5 cycles. After out_ready rises, the next beat follows with no bubble.
- Streaming: in1 alone sends 4 single-beat packets back to back, out_ready=1 -> 4 output beats on 4 consecutive cycles, all with out_sel=1.
- Reset mid-packet: assert rst after beat 2 of a 4-beat in0 packet -> out_valid=0 and ready low after the edge. After rst drops, an in1 single beat with in0 idle is granted (state is IDLE, not LOCK0).

Source files
------------

// File: rtl/stream_pkg.sv
`default_nettype none
// ==================================================================
// Module : stream_pkg
// Brief  : Shared stream types and default width for the merge path.
// Rev    : 1.0
// ==================================================================
package stream_pkg;

  localparam int STREAM_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/stream_out_reg.sv
`default_nettype none
// ==================================================================
// Module : stream_out_reg
// Brief  : Single-entry valid/ready register slot; exports slot_free.
// Rev    : 1.0
// ==================================================================
module stream_out_reg
  import stream_pkg::*;
#(
  parameter int WIDTH = STREAM_WIDTH + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_payload,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_payload,
  output logic             o_slot_free
);

  logic             r_valid;
  logic [WIDTH-1:0] r_payload;

  assign o_slot_free = !r_valid || i_ready;
  assign o_valid     = r_valid;
  assign o_payload   = r_payload;

  // Payload holds its last value when the slot drains without a refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
    end else if (o_slot_free) begin
      r_valid <= i_load;
      if (i_load) begin
        r_payload <= i_payload;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_mux2_rr.sv
`default_nettype none
// ==================================================================
// Module : stream_mux2_rr
// Brief  : 2:1 packet-locked round-robin stream merge, tagged output.
// Rev    : 1.0
// ==================================================================
module stream_mux2_rr
  import stream_pkg::*;
#(
  parameter int WIDTH = STREAM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic             out_sel,
  input  logic             out_ready
);

  localparam int C_SLOT_W = WIDTH + 2;

  arb_state_t          r_state;
  logic                r_prio;
  logic                w_grant_any;
  logic                w_grant_sel;
  logic                w_grant_ok;
  logic                w_slot_free;
  logic                w_accept;
  logic                w_sel_valid;
  logic                w_sel_last;
  logic [WIDTH-1:0]    w_sel_data;
  logic [C_SLOT_W-1:0] w_slot_in;
  logic [C_SLOT_W-1:0] w_slot_out;

  // A locked source keeps its grant even while its valid is low.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_sel = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant_any = in0_valid | in1_valid;
        w_grant_sel = (in0_valid & in1_valid) ? r_prio : in1_valid;
      end
      LOCK0: begin
        w_grant_any = 1'b1;
        w_grant_sel = 1'b0;
      end
      LOCK1: begin
        w_grant_any = 1'b1;
        w_grant_sel = 1'b1;
      end
      default: begin
        w_grant_any = 1'b0;
        w_grant_sel = 1'b0;
      end
    endcase
  end

  assign w_sel_data  = w_grant_sel ? in1_data  : in0_data;
  assign w_sel_last  = w_grant_sel ? in1_last  : in0_last;
  assign w_sel_valid = w_grant_sel ? in1_valid : in0_valid;

  assign w_grant_ok = w_grant_any & w_slot_free & !rst;
  assign in0_ready  = w_grant_ok & !w_grant_sel;
  assign in1_ready  = w_grant_ok &  w_grant_sel;
  assign w_accept   = w_grant_ok & w_sel_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_prio  <= 1'b0;
    end else if (w_accept) begin
      if (w_sel_last) begin
        r_state <= IDLE;
        r_prio  <= !w_grant_sel;
      end else begin
        r_state <= w_grant_sel ? LOCK1 : LOCK0;
      end
    end
  end

  assign w_slot_in = {w_sel_data, w_sel_last, w_grant_sel};

  stream_out_reg #(
    .WIDTH (C_SLOT_W)
  ) u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_accept),
    .i_payload   (w_slot_in),
    .i_ready     (out_ready),
    .o_valid     (out_valid),
    .o_payload   (w_slot_out),
    .o_slot_free (w_slot_free)
  );

  assign out_data = w_slot_out[C_SLOT_W-1:2];
  assign out_last = w_slot_out[1];
  assign out_sel  = w_slot_out[0];

endmodule
`default_nettype wire

// File: tb/tb_stream_mux2_rr.sv
`default_nettype none
// ==================================================================
// Module : tb_stream_mux2_rr
// Brief  : Directed + random bench for stream_mux2_rr with a packet model.
// Rev    : 1.0
// ==================================================================
module tb_stream_mux2_rr;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in0_data, in1_data, out_data;
  logic         in0_valid, in0_last, in0_ready;
  logic         in1_valid, in1_last, in1_ready;
  logic         out_valid, out_last, out_sel, out_ready;

  int n_total = 0;
  int n_pass  = 0;
  bit check_en = 1'b0;
  int cyc = 0;

  stream_mux2_rr #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_data  (in0_data),
    .in0_valid (in0_valid),
    .in0_last  (in0_last),
    .in0_ready (in0_ready),
    .in1_data  (in1_data),
    .in1_valid (in1_valid),
    .in1_last  (in1_last),
    .in1_ready (in1_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Packet-level model: owner is the source holding a packet open, -1 if none.
  bit         m_valid = 0, m_last = 0, m_sel = 0, m_prio = 0;
  logic [W-1:0] m_data = '0;
  int         m_owner = -1;
  bit         n_valid = 0, n_last = 0, n_sel = 0, n_prio = 0;
  logic [W-1:0] n_data = '0;
  int         n_owner = -1;

  always @(negedge clk) begin
    int cand;
    bit free, e0, e1;
    free = !m_valid || out_ready;
    if (m_owner >= 0)               cand = m_owner;
    else if (in0_valid && in1_valid) cand = m_prio ? 1 : 0;
    else if (in0_valid)             cand = 0;
    else if (in1_valid)             cand = 1;
    else                            cand = -1;
    e0 = !rst && free && (cand == 0);
    e1 = !rst && free && (cand == 1);
    if (check_en)
      check("cycle_model",
            {19'd0, out_valid, out_last, out_sel, in0_ready, in1_ready, out_data},
            {19'd0, m_valid, m_last, m_sel, e0, e1, m_data});
    n_valid = m_valid; n_last = m_last; n_sel = m_sel; n_data = m_data;
    n_prio = m_prio; n_owner = m_owner;
    if (rst) begin
      n_valid = 0; n_last = 0; n_sel = 0; n_data = '0; n_prio = 0; n_owner = -1;
    end else if ((e0 && in0_valid) || (e1 && in1_valid)) begin
      n_valid = 1;
      n_sel   = (cand == 1);
      n_data  = n_sel ? in1_data : in0_data;
      n_last  = n_sel ? in1_last : in0_last;
      if (n_last) begin
        n_owner = -1;
        n_prio  = !n_sel;
      end else begin
        n_owner = cand;
      end
    end else if (out_ready) begin
      n_valid = 0;
    end
  end

  always @(posedge clk) begin
    m_valid = n_valid; m_last = n_last; m_sel = n_sel; m_data = n_data;
    m_prio = n_prio; m_owner = n_owner;
  end

  // Queue-driven sources: entries are {last, data}; outputs logged as {sel, last, data}.
  logic [8:0] q0[$], q1[$];
  logic [9:0] outq[$];
  int         outcyc[$];
  bit         lock_violation;

  task automatic idle_inputs();
    in0_valid = 0; in1_valid = 0; in0_last = 0; in1_last = 0;
    in0_data = '0; in1_data = '0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs(); out_ready = 1;
    @(posedge clk); #1;
    rst = 0;
    outq.delete(); outcyc.delete(); q0.delete(); q1.delete();
    lock_violation = 0;
  endtask

  task automatic run(input int cycles);
    bit a0, a1;
    for (int c = 0; c < cycles; c++) begin
      in0_valid = (q0.size() > 0);
      if (in0_valid) {in0_last, in0_data} = q0[0];
      in1_valid = (q1.size() > 0);
      if (in1_valid) {in1_last, in1_data} = q1[0];
      #1;
      a0 = in0_valid && in0_ready;
      a1 = in1_valid && in1_ready;
      if (in1_ready && q0.size() > 0) lock_violation = 1;
      if (out_valid && out_ready) begin
        outq.push_back({out_sel, out_last, out_data});
        outcyc.push_back(cyc);
      end
      @(posedge clk); #1;
      if (a0) void'(q0.pop_front());
      if (a1) void'(q1.pop_front());
    end
    in0_valid = 0; in1_valid = 0;
  endtask

  function automatic logic [31:0] get_out(input int i);
    if (i < outq.size()) return {22'd0, outq[i]};
    return 32'hFFFF;
  endfunction

  function automatic int get_cyc(input int i);
    if (i < outcyc.size()) return outcyc[i];
    return -1000;
  endfunction

  initial begin
    logic [9:0] exp_cont [4];
    logic [9:0] exp_lock [4];
    exp_cont[0] = 10'h110; exp_cont[1] = 10'h320; exp_cont[2] = 10'h111; exp_cont[3] = 10'h321;
    exp_lock[0] = 10'h001; exp_lock[1] = 10'h002; exp_lock[2] = 10'h103; exp_lock[3] = 10'h355;

    rst = 1; idle_inputs(); out_ready = 1; lock_violation = 0;
    @(posedge clk); @(posedge clk); #1;
    check_en = 1;
    rst = 0;
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 0);
    check("reset_out_fields", {22'd0, out_sel, out_last, out_data}, 0);
    check("reset_readies", {30'd0, in0_ready, in1_ready}, 0);
    @(posedge clk); #1;

    // Single beat
    do_reset();
    in0_data = 8'hA5; in0_last = 1; in0_valid = 1;
    #1 check("single_in0_ready", {31'd0, in0_ready}, 1);
    @(posedge clk); #1;
    in0_valid = 0; in0_last = 0;
    check("single_out_valid", {31'd0, out_valid}, 1);
    check("single_out_data", {24'd0, out_data}, 32'hA5);
    check("single_sel_last", {30'd0, out_sel, out_last}, 32'h1);

    // Contention, single-beat packets alternate
    do_reset();
    q0.push_back(9'h110); q0.push_back(9'h111);
    q1.push_back(9'h120); q1.push_back(9'h121);
    run(8);
    check("cont_count", outq.size(), 4);
    for (int i = 0; i < 4; i++) check("cont_beat", get_out(i), {22'd0, exp_cont[i]});

    // Packet lock
    do_reset();
    q0.push_back(9'h001); q0.push_back(9'h002); q0.push_back(9'h103);
    q1.push_back(9'h155);
    run(8);
    check("lock_count", outq.size(), 4);
    for (int i = 0; i < 4; i++) check("lock_beat", get_out(i), {22'd0, exp_lock[i]});
    check("lock_in1_ready_early", {31'd0, lock_violation}, 0);

    // Backpressure
    do_reset();
    in0_data = 8'h33; in0_last = 1; in0_valid = 1;
    @(posedge clk); #1;
    in0_valid = 0; in0_last = 0;
    in1_data = 8'h44; in1_last = 1; in1_valid = 1;
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold", {21'd0, out_valid, out_sel, out_last, out_data}, 32'h533);
      check("bp_readies", {30'd0, in0_ready, in1_ready}, 0);
      @(posedge clk); #1;
    end
    out_ready = 1;
    #1 check("bp_release_ready", {31'd0, in1_ready}, 1);
    @(posedge clk); #1;
    in1_valid = 0; in1_last = 0;
    check("bp_no_bubble", {22'd0, out_valid, out_sel, out_data}, 32'h344);

    // Streaming from in1 alone
    do_reset();
    for (int i = 0; i < 4; i++) q1.push_back(9'h1A0 + 9'(i));
    run(8);
    check("stream_count", outq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("stream_beat", get_out(i), 32'h3A0 + i);
      check("stream_spacing", get_cyc(i) - get_cyc(0), i);
    end

    // Reset mid-packet
    do_reset();
    in0_valid = 1; in0_last = 0; in0_data = 8'h81;
    @(posedge clk); #1;
    in0_data = 8'h82;
    @(posedge clk); #1;
    rst = 1; in0_data = 8'h83;
    @(posedge clk); #1;
    check("rstmid_out_valid", {31'd0, out_valid}, 0);
    check("rstmid_readies", {30'd0, in0_ready, in1_ready}, 0);
    rst = 0; in0_valid = 0;
    in1_valid = 1; in1_last = 1; in1_data = 8'h77;
    #1 check("rstmid_in1_granted", {31'd0, in1_ready}, 1);
    @(posedge clk); #1;
    in1_valid = 0; in1_last = 0;
    check("rstmid_in1_out", {22'd0, out_valid, out_sel, out_data}, 32'h377);

    // Randomized traffic; the per-cycle model check covers every cycle
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      in0_valid = ($urandom_range(0, 99) < 60);
      in0_data  = 8'($urandom);
      in0_last  = ($urandom_range(0, 2) == 0);
      in1_valid = ($urandom_range(0, 99) < 60);
      in1_data  = 8'($urandom);
      in1_last  = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 99) < 70);
      rst       = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
    end
    rst = 0; idle_inputs(); out_ready = 1;
    repeat (4) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
